// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 single-bit mux.
// Define MUX_ARB_TIMEOUT_EN to force rotation after MAX_HOLD consecutive grant cycles.
module mux_rr_arbiter #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       S1,
  output logic       S0,
  output logic       VALID
);

  localparam int unsigned GapW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned HoldW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned GapLast  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned HoldLast = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [GapW-1:0]  gap_q, gap_d;

  logic       arb_found;
  logic [1:0] arb_idx;
  logic [1:0] cand;
  logic       release_now;
  logic       forced;

  // First requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!arb_found && REQ[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Only rotate away when someone else is actually waiting.
  assign forced = (hold_q == HoldW'(HoldLast)) && (|(REQ & ~gnt_q));
`else
  assign forced = 1'b0;
`endif

  assign release_now = !REQ[sel_q] || forced;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << arb_idx;
          sel_d   = arb_idx;
          valid_d = 1'b1;
          ptr_d   = arb_idx + 2'd1;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (!release_now) begin
          if (hold_q != HoldW'(HoldLast)) hold_d = hold_q + 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = StGap;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          gap_d   = '0;
        end else if (arb_found) begin
          // Direct handover; the pointer already skips past the old holder.
          state_d = StGrant;
          gnt_d   = 4'b0001 << arb_idx;
          sel_d   = arb_idx;
          valid_d = 1'b1;
          ptr_d   = arb_idx + 2'd1;
          hold_d  = '0;
        end else begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GapLast)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign GNT   = gnt_q;
  assign S1    = sel_q[1];
  assign S0    = sel_q[0];
  assign VALID = valid_q;

endmodule
